// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three-source round-robin writeback arbiter with per-source 2-deep FIFOs
module cdb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  input  logic [2:0]  s0_entry,
  input  logic [63:0] s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [2:0]  s1_entry,
  input  logic [63:0] s1_data,
  output logic        s1_ready,
  input  logic        s2_valid,
  input  logic [2:0]  s2_entry,
  input  logic [63:0] s2_data,
  output logic        s2_ready,
  input  logic        flush,
  input  logic        hold,
  output logic        data_ready,
  output logic        commit_ready,
  output logic [2:0]  data_entry,
  output logic [63:0] Data_in,
  output logic [1:0]  grant_src
);
  logic [2:0]  vld, rdy, push, pop;
  logic [2:0]  ent_in [3];
  logic [63:0] dat_in [3];
  logic [2:0]  ent_q [3][2], ent_d [3][2];
  logic [63:0] dat_q [3][2], dat_d [3][2];
  logic [1:0]  cnt_q [3], cnt_d [3];
  logic [2:0]  wp_q, wp_d, rp_q, rp_d;
  logic [1:0]  last_q, last_d, src_q, src_d, sel;
  logic [1:0]  ord [3];
  logic        dr_q, dr_d, found, gnt;
  logic [2:0]  de_q, de_d;
  logic [63:0] din_q, din_d;
  function automatic logic [1:0] nxt(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
  assign vld = {s2_valid, s1_valid, s0_valid};
  assign ent_in[0] = s0_entry;
  assign ent_in[1] = s1_entry;
  assign ent_in[2] = s2_entry;
  assign dat_in[0] = s0_data;
  assign dat_in[1] = s1_data;
  assign dat_in[2] = s2_data;
  assign {s2_ready, s1_ready, s0_ready} = rdy;
  assign data_ready = dr_q;
  assign commit_ready = dr_q;
  assign data_entry = de_q;
  assign Data_in = din_q;
  assign grant_src = src_q;
  always_comb begin
    rdy = '0;
    for (int s = 0; s < 3; s++) rdy[s] = cnt_q[s] < 2'd2 && !flush && !rst;
    push = vld & rdy;
    ord[0] = nxt(last_q);
    ord[1] = nxt(ord[0]);
    ord[2] = nxt(ord[1]);
    found = 1'b0;
    sel = 2'd0;
    for (int k = 0; k < 3; k++)
      if (!found && cnt_q[ord[k]] != 2'd0) begin
        found = 1'b1;
        sel = ord[k];
      end
    gnt = found && !hold && !flush && !rst;
    pop = gnt ? 3'b001 << sel : 3'b000;
    ent_d = ent_q;
    dat_d = dat_q;
    wp_d = wp_q;
    rp_d = rp_q;
    last_d = gnt ? sel : last_q;
    dr_d = gnt;
    src_d = gnt ? sel : 2'd3;
    de_d = gnt ? ent_q[sel][rp_q[sel]] : de_q;
    din_d = gnt ? dat_q[sel][rp_q[sel]] : din_q;
    for (int s = 0; s < 3; s++) begin
      if (push[s]) begin
        ent_d[s][wp_q[s]] = ent_in[s];
        dat_d[s][wp_q[s]] = dat_in[s];
        wp_d[s] = ~wp_q[s];
      end
      if (pop[s]) rp_d[s] = ~rp_q[s];
      cnt_d[s] = flush ? 2'd0 : cnt_q[s] + {1'b0, push[s]} - {1'b0, pop[s]};
    end
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    dat_q <= dat_d;
    if (rst) begin
      cnt_q <= '{default: 2'd0};
      wp_q <= '0;
      rp_q <= '0;
      last_q <= 2'd2;
      dr_q <= 1'b0;
      src_q <= 2'd3;
      de_q <= '0;
      din_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      last_q <= last_d;
      dr_q <= dr_d;
      src_q <= src_d;
      de_q <= de_d;
      din_q <= din_d;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  logic        clk = 0, rst = 0, flush = 0, hold = 0;
  logic        s0_valid = 0, s1_valid = 0, s2_valid = 0;
  logic [2:0]  s0_entry = 0, s1_entry = 0, s2_entry = 0;
  logic [63:0] s0_data = 0, s1_data = 0, s2_data = 0;
  logic        s0_ready, s1_ready, s2_ready, data_ready, commit_ready;
  logic [2:0]  data_entry;
  logic [63:0] Data_in;
  logic [1:0]  grant_src;
  int checks = 0, failures = 0;
  cdb_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_entry(s0_entry), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_entry(s1_entry), .s1_data(s1_data), .s1_ready(s1_ready),
    .s2_valid(s2_valid), .s2_entry(s2_entry), .s2_data(s2_data), .s2_ready(s2_ready),
    .flush(flush), .hold(hold), .data_ready(data_ready), .commit_ready(commit_ready),
    .data_entry(data_entry), .Data_in(Data_in), .grant_src(grant_src)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    s0_valid = 1; s1_valid = 1; s2_valid = 1;
    step();
    checks++; if ({s2_ready, s1_ready, s0_ready} !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", {s2_ready, s1_ready, s0_ready}); end
    checks++; if (data_ready !== 0 || commit_ready !== 0) begin failures++; $display("FAIL reset_dr got=%b%b exp=00", data_ready, commit_ready); end
    checks++; if (grant_src !== 2'd3) begin failures++; $display("FAIL reset_gs got=%0d exp=3", grant_src); end
    checks++; if (data_entry !== 3'd0 || Data_in !== 64'd0) begin failures++; $display("FAIL reset_data got=%0d/%h exp=0/0", data_entry, Data_in); end
    s0_valid = 0; s1_valid = 0; s2_valid = 0;
    rst = 0;
    #1;
    checks++; if ({s2_ready, s1_ready, s0_ready} !== 3'b111) begin failures++; $display("FAIL post_reset_ready got=%b exp=111", {s2_ready, s1_ready, s0_ready}); end
  endtask
  task automatic test_single();
    do_reset();
    s0_valid = 1; s0_entry = 5; s0_data = 64'hDEAD;
    step();
    s0_valid = 0;
    checks++; if (data_ready !== 0) begin failures++; $display("FAIL single_e1_dr got=%b exp=0", data_ready); end
    step();
    checks++; if (data_ready !== 1 || commit_ready !== 1) begin failures++; $display("FAIL single_e2_dr got=%b%b exp=11", data_ready, commit_ready); end
    checks++; if (data_entry !== 3'd5 || Data_in !== 64'hDEAD || grant_src !== 2'd0) begin failures++; $display("FAIL single_e2_data got=%0d/%h/%0d exp=5/dead/0", data_entry, Data_in, grant_src); end
    step();
    checks++; if (data_ready !== 0 || commit_ready !== 0 || grant_src !== 2'd3) begin failures++; $display("FAIL single_e3 got=%b%b/%0d exp=00/3", data_ready, commit_ready, grant_src); end
    checks++; if (data_entry !== 3'd5 || Data_in !== 64'hDEAD) begin failures++; $display("FAIL single_e3_hold got=%0d/%h exp=5/dead", data_entry, Data_in); end
  endtask
  task automatic test_round_robin();
    do_reset();
    s0_valid = 1; s0_entry = 1; s0_data = 64'h11;
    s1_valid = 1; s1_entry = 2; s1_data = 64'h22;
    s2_valid = 1; s2_entry = 3; s2_data = 64'h33;
    step();
    s0_valid = 0; s1_valid = 0; s2_valid = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (data_ready !== 1 || grant_src !== 2'(k) || data_entry !== 3'(k + 1) || Data_in !== 64'(17 * (k + 1))) begin failures++; $display("FAIL rr_%0d got=%b/%0d/%0d/%h exp=1/%0d/%0d/%h", k, data_ready, grant_src, data_entry, Data_in, k, k + 1, 17 * (k + 1)); end
    end
    step();
    checks++; if (data_ready !== 0 || grant_src !== 2'd3) begin failures++; $display("FAIL rr_idle got=%b/%0d exp=0/3", data_ready, grant_src); end
  endtask
  task automatic test_back_pressure();
    do_reset();
    hold = 1;
    s1_valid = 1; s1_entry = 4; s1_data = 64'h44;
    step();
    s1_entry = 6; s1_data = 64'h66;
    step();
    checks++; if (s1_ready !== 0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", s1_ready); end
    s1_entry = 7; s1_data = 64'h77;
    step();
    checks++; if (data_ready !== 0 || s1_ready !== 0) begin failures++; $display("FAIL bp_hold got=%b/%b exp=0/0", data_ready, s1_ready); end
    s1_valid = 0;
    hold = 0;
    step();
    checks++; if (data_ready !== 1 || grant_src !== 2'd1 || data_entry !== 3'd4 || Data_in !== 64'h44) begin failures++; $display("FAIL bp_first got=%b/%0d/%0d/%h exp=1/1/4/44", data_ready, grant_src, data_entry, Data_in); end
    checks++; if (s1_ready !== 1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", s1_ready); end
    step();
    checks++; if (data_ready !== 1 || data_entry !== 3'd6 || Data_in !== 64'h66) begin failures++; $display("FAIL bp_second got=%b/%0d/%h exp=1/6/66", data_ready, data_entry, Data_in); end
    step();
    checks++; if (data_ready !== 0 || grant_src !== 2'd3) begin failures++; $display("FAIL bp_no_third got=%b/%0d exp=0/3", data_ready, grant_src); end
  endtask
  task automatic test_flush();
    do_reset();
    hold = 1;
    s0_valid = 1; s0_entry = 1; s0_data = 64'hA1;
    s1_valid = 1; s1_entry = 2; s1_data = 64'hA2;
    step();
    s0_valid = 0; s1_valid = 0;
    hold = 0;
    flush = 1;
    s2_valid = 1; s2_entry = 3; s2_data = 64'hA3;
    #1;
    checks++; if (s2_ready !== 0) begin failures++; $display("FAIL flush_ready got=%b exp=0", s2_ready); end
    step();
    checks++; if (data_ready !== 0 || commit_ready !== 0 || grant_src !== 2'd3) begin failures++; $display("FAIL flush_edge got=%b%b/%0d exp=00/3", data_ready, commit_ready, grant_src); end
    flush = 0;
    s2_valid = 0;
    #1;
    checks++; if ({s2_ready, s1_ready, s0_ready} !== 3'b111) begin failures++; $display("FAIL flush_after_ready got=%b exp=111", {s2_ready, s1_ready, s0_ready}); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (data_ready !== 0) begin failures++; $display("FAIL flush_drop_%0d got=%b exp=0 entry=%0d", k, data_ready, data_entry); end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    s0_valid = 1; s0_entry = 7; s0_data = 64'hB7;
    step();
    s0_valid = 0;
    step();
    checks++; if (grant_src !== 2'd0 || data_entry !== 3'd7) begin failures++; $display("FAIL rm_pre got=%0d/%0d exp=0/7", grant_src, data_entry); end
    hold = 1;
    s0_valid = 1; s0_entry = 1; s1_valid = 1; s1_entry = 2; s2_valid = 1; s2_entry = 3;
    step();
    s0_valid = 0; s1_valid = 0; s2_valid = 0;
    hold = 0;
    rst = 1;
    #1;
    checks++; if ({s2_ready, s1_ready, s0_ready} !== 3'b000) begin failures++; $display("FAIL rm_ready got=%b exp=000", {s2_ready, s1_ready, s0_ready}); end
    step();
    checks++; if (data_ready !== 0 || grant_src !== 2'd3 || data_entry !== 3'd0 || Data_in !== 64'd0) begin failures++; $display("FAIL rm_outputs got=%b/%0d/%0d/%h exp=0/3/0/0", data_ready, grant_src, data_entry, Data_in); end
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (data_ready !== 0) begin failures++; $display("FAIL rm_drop_%0d got=%b exp=0 entry=%0d", k, data_ready, data_entry); end
    end
    s0_valid = 1; s0_entry = 4; s1_valid = 1; s1_entry = 5; s2_valid = 1; s2_entry = 6;
    step();
    s0_valid = 0; s1_valid = 0; s2_valid = 0;
    step();
    checks++; if (data_ready !== 1 || grant_src !== 2'd0 || data_entry !== 3'd4) begin failures++; $display("FAIL rm_first got=%b/%0d/%0d exp=1/0/4", data_ready, grant_src, data_entry); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
REQ-002 For each source s = 0 (ALU), 1 (MUL), 2 (LSU), it SHALL have:
- s<s>_valid  in  1  result present.
- s<s>_entry  in  3  ROB entry tag of the result.
- s<s>_data  in  64  result value.
- s<s>_ready  out  1  source may present a result this cycle.
REQ-003 It SHALL have the following further ports:
- flush  in  1  mispredict; discard all buffered results.
- hold  in  1  ROB cannot accept a writeback this cycle.
- data_ready  out  1  writeback strobe to ROB (pulse).
- commit_ready  out  1  mark entry ready-to-commit; always equal to data_ready.
- data_entry  out  3  ROB entry being written.
- Data_in  out  64  value written into the ROB entry.
- grant_src  out  2  source of the current writeback (0..2); 3 when idle.

Function
REQ-004 Each source SHALL own a 2-deep FIFO of {entry[2:0], data[63:0]}, with a 2-bit count.
REQ-005 s<s>_ready SHALL be combinational, equal to (count_s < 2) AND NOT flush AND NOT rst.
REQ-006 A push SHALL occur at a posedge when s<s>_valid AND s<s>_ready; a valid source with ready low SHALL NOT be captured, and the source holds its result.
REQ-007 A full FIFO SHALL NOT accept a push in the same cycle it is popped; ready depends only on count.
REQ-008 Each cycle without rst, flush or hold, the block SHALL grant at most one source with a non-empty FIFO.
REQ-009 Grant order SHALL be round-robin: priority starts at (last_grant+1) mod 3 and wraps 2->0.
REQ-010 last_grant SHALL update only when a grant occurs.
REQ-011 On a grant, the granted FIFO head SHALL be popped.
REQ-012 On a grant, at the same posedge, the block SHALL register data_ready=1, commit_ready=1, data_entry=head.entry, Data_in=head.data, grant_src=s.
REQ-013 With no grant, data_ready and commit_ready SHALL register 0 and grant_src SHALL register 3; data_entry and Data_in SHALL hold their previous values.
REQ-014 Latency: a result pushed at edge N into an empty FIFO SHALL appear on the outputs at edge N+1 at the earliest, when it is that source's turn and hold=0.
REQ-015 Each data_ready pulse SHALL correspond to exactly one pushed result; no result is duplicated or lost except by flush/rst.
REQ-016 Results from one source SHALL be written back in push order.
REQ-017 While hold=1, no grant and no pop SHALL occur; pushes SHALL continue while space remains.
REQ-018 flush=1 SHALL at that edge clear all counts and pointers, drop any push that cycle, and register data_ready=0, commit_ready=0, grant_src=3.
REQ-019 flush SHALL leave last_grant unchanged.
REQ-020 Priority SHALL be rst > flush > hold > normal operation.
REQ-021 FIFO read/write pointers SHALL be 1 bit each and wrap 1->0.
REQ-022 count SHALL never exceed 2 or underflow below 0.

Reset
REQ-023 On rst at a posedge, the block SHALL:
- clear all FIFO counts and pointers;
- set last_grant=2, so source 0 has first priority;
- set data_ready=0, commit_ready=0, data_entry=0, Data_in=0, grant_src=3.
REQ-024 A rst asserted mid-operation SHALL discard all buffered results within that edge; all s<s>_ready SHALL be 0 while rst=1.

Verification
REQ-025 The bench SHALL cover single result: s0 pushes entry=5, data=0xDEAD at edge 1 -> at edge 2 data_ready=1, commit_ready=1, data_entry=5, Data_in=0xDEAD, grant_src=0; at edge 3 data_ready=0, grant_src=3.
REQ-026 The bench SHALL cover round-robin: all three sources push one result at edge 1 (entries 1,2,3) -> grant_src sequence 0,1,2 at edges 2,3,4 with data_entry 1,2,3.
REQ-027 The bench SHALL cover back-pressure: s1 pushes entries 4,6 with hold=1 -> s1_ready=0 after the second push; a third valid is not captured; releasing hold writes back entries 4 then 6 in order.
REQ-028 The bench SHALL cover flush: two results buffered plus an s2 push in the flush cycle -> no data_ready for any of them; all s<s>_ready=1 on the next cycle.
REQ-029 The bench SHALL cover reset mid-operation: rst asserted with FIFOs non-empty -> outputs reach their reset values next cycle and buffered results never appear; after rst, the first simultaneous request is granted to source 0.
